// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/bubble sequencing with load-use, branch and dmem handshake control
//   in : clk, rst, id_rs1_addr/id_rs2_addr/id_uses_rs1/id_uses_rs2 (ID sources),
//        ex_mem_read_en/ex_rd_addr/ex_branch_taken (EX), mem_mem_read_en/mem_mem_write_en (MEM), dmem_ready
//   out: dmem_req, pc_stall, pc_redirect_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//        ex_mem_stall, mem_wb_bubble, mem_fault (sticky timeout), stall_count (pc_stall cycles, wraps)
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read_en,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_branch_taken,
  input  logic        mem_mem_read_en,
  input  logic        mem_mem_write_en,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        pc_redirect_en,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_bubble,
  output logic        mem_fault,
  output logic [31:0] stall_count
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, FAULT = 2'd2;
  logic [1:0] state;
  logic [15:0] wait_cnt;
  logic mem_acc, load_use, mem_stall, ms, br, lu;
  assign mem_acc = mem_mem_read_en | mem_mem_write_en;
  assign load_use = ex_mem_read_en & (ex_rd_addr != 5'd0) &
                    ((id_uses_rs1 & (ex_rd_addr == id_rs1_addr)) | (id_uses_rs2 & (ex_rd_addr == id_rs2_addr)));
  always_comb mem_stall = state == FAULT ? 1'b1 : state == WAIT ? ~dmem_ready : mem_acc & ~dmem_ready;
  // mem_stall outranks a taken branch so a branch frozen in EX survives the freeze
  assign ms = ~rst & mem_stall;
  assign br = ~rst & ~mem_stall & ex_branch_taken;
  assign lu = ~rst & ~mem_stall & ~ex_branch_taken & load_use;
  assign dmem_req = ~rst & (state == WAIT | (state == IDLE & mem_acc));
  assign pc_stall = ms | lu;
  assign if_id_stall = ms | lu;
  assign id_ex_stall = ms;
  assign ex_mem_stall = ms;
  assign mem_wb_bubble = ms;
  assign pc_redirect_en = br;
  assign if_id_flush = br;
  assign id_ex_flush = br | lu;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      mem_fault <= 1'b0;
      stall_count <= '0;
    end else begin
      if (pc_stall) stall_count <= stall_count + 32'd1;
      case (state)
        IDLE: if (mem_acc & ~dmem_ready) begin
          state <= WAIT;
          wait_cnt <= 16'd1;
        end
        WAIT: if (dmem_ready) begin
          state <= IDLE;
          wait_cnt <= '0;
        end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state <= FAULT;
          mem_fault <= 1'b1;
        end else wait_cnt <= wait_cnt + 16'd1;
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl with TIMEOUT_CYCLES=4
module tb_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs1_addr = 0, id_rs2_addr = 5'd9, ex_rd_addr = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 1, ex_mem_read_en = 0, ex_branch_taken = 0;
  logic mem_mem_read_en = 0, mem_mem_write_en = 0, dmem_ready = 0;
  logic dmem_req, pc_stall, pc_redirect_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_bubble, mem_fault;
  logic [31:0] stall_count;
  int checks = 0, errors = 0;
  typedef struct { logic [9:0] ctl; logic [31:0] cnt; string nm; } exp_t;
  exp_t q[$];
  localparam logic [9:0] NONE = 10'b0000000000, REQ = 10'b1000000000, LU = 10'b0101001000,
                         BR = 10'b0010101000, MS = 10'b0101010110, FLT = 10'b0000000001;
  hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read_en(ex_mem_read_en),
    .ex_rd_addr(ex_rd_addr), .ex_branch_taken(ex_branch_taken), .mem_mem_read_en(mem_mem_read_en),
    .mem_mem_write_en(mem_mem_write_en), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_stall(pc_stall), .pc_redirect_en(pc_redirect_en), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble), .mem_fault(mem_fault),
    .stall_count(stall_count));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [4:0] rs1, input logic u1, input logic exl,
                      input logic [4:0] exrd, input logic b, input logic mr, input logic mw,
                      input logic rdy, input logic [9:0] ectl, input logic [31:0] ecnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1_addr = rs1; id_uses_rs1 = u1; ex_mem_read_en = exl; ex_rd_addr = exrd;
    ex_branch_taken = b; mem_mem_read_en = mr; mem_mem_write_en = mw; dmem_ready = rdy;
    e.ctl = ectl; e.cnt = ecnt; e.nm = nm;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    logic [9:0] act;
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {dmem_req, pc_stall, pc_redirect_en, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_fault};
      checks += 2;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b want %b", e.nm, act, e.ctl);
      end
      if (stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_count got %0d want %0d", e.nm, stall_count, e.cnt);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    //   rst rs1   u1 exl exrd  br mr mw rdy  ctl        cnt
    step(1, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, NONE,      0,  "reset_forced");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      0,  "idle");
    step(0, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, LU,        0,  "load_use_rs1");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      1,  "after_load_use");
    step(0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, NONE,      1,  "rd_zero");
    step(0, 5'd0, 0, 1, 5'd9, 0, 0, 0, 0, LU,        1,  "load_use_rs2");
    step(0, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, BR,        2,  "branch_over_lu");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, REQ,       2,  "zero_wait");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, REQ | MS,  2,  "wait_1");
    step(0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, REQ | MS,  3,  "wait_2_branch");
    step(0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, REQ | MS,  4,  "wait_3_branch");
    step(0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 1, REQ | BR,  5,  "release_branch");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      5,  "after_release");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, REQ,       5,  "ld_st_single");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, NONE,      5,  "ready_no_acc");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  5,  "to_1");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  6,  "to_2");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  7,  "to_3");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  8,  "to_4");
    step(0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 1, MS | FLT,  9,  "fault_ready_ignored");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, MS | FLT,  10, "fault_hold");
    step(1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, FLT,       11, "fault_rst");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      0,  "fault_cleared");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  0,  "mw_1");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  1,  "mw_2");
    step(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, REQ | MS,  2,  "mw_3");
    step(1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, NONE,      3,  "mid_wait_rst");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      0,  "post_rst_idle");
    step(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, NONE,      0,  "post_rst_idle2");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core.
- Generates stall, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and resolves taken-branch flushes.
- Runs a data-memory handshake FSM that freezes the pipeline while a MEM-stage load or store waits for dmem_ready, with a timeout fault.

Parameters:
TIMEOUT_CYCLES, 64, WAIT cycles allowed before mem_fault; legal range 2..65535.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
id_rs1_addr  input  5  rs1 index of the instruction in ID
id_rs2_addr  input  5  rs2 index of the instruction in ID
id_uses_rs1  input  1  the ID instruction reads rs1
id_uses_rs2  input  1  the ID instruction reads rs2
ex_mem_read_en  input  1  the EX instruction is a load
ex_rd_addr  input  5  destination register of the EX instruction
ex_branch_taken  input  1  the EX instruction resolved as a taken branch or jump
mem_mem_read_en  input  1  a load is in MEM (from EX/MEM)
mem_mem_write_en  input  1  a store is in MEM (from EX/MEM)
dmem_ready  input  1  data memory completes the current access this cycle
dmem_req  output  1  data memory access request
pc_stall  output  1  hold the PC
pc_redirect_en  output  1  load the branch target into the PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID to a NOP
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  clear ID/EX to a bubble (control signals zero)
ex_mem_stall  output  1  hold EX/MEM
mem_wb_bubble  output  1  load a bubble into MEM/WB
mem_fault  output  1  sticky data-memory timeout flag
stall_count  output  32  count of cycles in which pc_stall=1; wraps

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, wait_cnt=0, mem_fault=0, stall_count=0.
  - While rst=1, every control output is forced to 0.
- Derived terms:
  - mem_acc = mem_mem_read_en | mem_mem_write_en.
  - load_use = ex_mem_read_en & (ex_rd_addr!=0) & ((id_uses_rs1 & ex_rd_addr==id_rs1_addr) | (id_uses_rs2 & ex_rd_addr==id_rs2_addr)).
- FSM states: IDLE, WAIT, FAULT.
  - IDLE: dmem_req=mem_acc.
    - mem_acc & dmem_ready: zero-wait access; no memory stall; stay IDLE.
    - mem_acc & ~dmem_ready: mem_stall=1 this cycle; next state WAIT; wait_cnt<=1.
  - WAIT: dmem_req=1, mem_stall=1, except in the dmem_ready cycle.
    - dmem_ready: mem_stall=0 that cycle so the pipeline advances; next state IDLE; wait_cnt<=0.
    - ~dmem_ready & wait_cnt==TIMEOUT_CYCLES-1: next state FAULT; mem_fault<=1.
    - Otherwise: wait_cnt<=wait_cnt+1.
  - FAULT: dmem_req=0, mem_stall=1 permanently; only rst exits.
- Combinational outputs, all same cycle, no latency. Priority: mem_stall > branch > load_use.
  - mem_stall=1:
    - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble = 1.
    - All flushes and pc_redirect_en = 0, so a branch frozen in EX is kept, not lost.
  - else ex_branch_taken=1:
    - pc_redirect_en, if_id_flush, id_ex_flush = 1; pc_stall=0.
    - A simultaneous load_use is ignored because the ID instruction is wrong-path.
  - else load_use=1: pc_stall, if_id_stall, id_ex_flush = 1; all other controls 0.
  - else all controls = 0.
- Register updates:
  - stall_count increments by 1 each cycle with pc_stall=1; wraps from 0xFFFFFFFF to 0.
  - mem_fault is registered and holds until rst.
- Boundary cases:
  - A store and a load both asserted in MEM is treated as a single access.
  - dmem_ready outside IDLE/WAIT with mem_acc=1, or with mem_acc=0 in IDLE, is ignored.
  - If rst is asserted mid-WAIT, the FSM returns to IDLE the next cycle with no residual stall.

Test Plan:
- Load-use: ex_mem_read_en=1, ex_rd_addr=5, id_rs1_addr=5, id_uses_rs1=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for 1 cycle; stall_count=1. Repeat with ex_rd_addr=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 with the load-use condition above -> pc_redirect_en=1, if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Zero-wait memory: mem_mem_read_en=1, dmem_ready=1 -> dmem_req=1, no stall, state stays IDLE.
- 3-cycle wait: mem_mem_write_en=1, dmem_ready low for 3 cycles then high.
  - The 3 low cycles: ex_mem_stall=1 and mem_wb_bubble=1.
  - ex_branch_taken=1 during the wait -> no flush and no redirect until release.
  - Release cycle: all stalls 0; stall_count=3.
- Timeout: TIMEOUT_CYCLES=4, mem_mem_read_en=1, dmem_ready=0 -> mem_fault=1 after 4 stalled cycles; stalls persist; rst clears mem_fault, stall_count and state.
- Reset mid-WAIT: rst=1 after 2 WAIT cycles -> all outputs 0 while rst=1; after release with mem_acc=0, no stall.
